deserializer_out: RTL and testbench

Receive-side stage that consumes the 1-bit symbol stream produced by the transmit serializer. Each symbol is 9 bits, `{k, byte}`. A frame is one comma symbol (k=1, 0x3C) followed by three data symbols (k=0). The block hunts for comma alignment, tracks frame slots, and reassembles each frame's three bytes into one 24-bit word with a single-cycle valid. It also reports lock and symbol errors to the downstream link logic.

---
 rtl/deserializer_out.sv | 196 +++++++++++++++++++
 tb/tb_deserializer_out.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_out.sv
// Receive-side deserializer: hunts for comma alignment on a 1-bit stream of
// 9-bit {k, byte} symbols and reassembles comma + three data symbols into 24-bit words.
module deserializer_out #(
  parameter int MISS_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_i,
  output logic [23:0] data_o,
  output logic        valid_o,
  output logic        lock_o,
  output logic        err_o,
  output logic [1:0]  slot_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [8:0] COMMA      = 9'h13C;
  localparam logic [3:0] MISS_LIMIT = 4'(MISS_MAX);
  localparam logic [3:0] LAST_BIT   = 4'd8;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  state_t      state_reg, state_next;
  logic [8:0]  sr_reg;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [1:0]  slot_reg, slot_next;
  logic [3:0]  miss_reg, miss_next;
  logic [23:0] data_reg;
  logic        valid_reg;
  logic        err_reg;
  logic [15:0] frame_cnt_reg;
  logic [1:0][7:0] lanes;

  logic is_comma;
  logic is_k;
  logic boundary;
  logic comma_ev;
  logic abort_ev;
  logic store_ev;
  logic complete_ev;
  logic bad_ev;
  logic miss_hit;
  logic [3:0] miss_inc;

  assign is_comma = (sr_reg == COMMA);
  assign is_k     = sr_reg[8];
  assign boundary = (state_reg == ST_LOCKED) && (bit_cnt_reg == LAST_BIT);
  assign miss_inc = miss_reg + 4'd1;

  // Serial shift register, LSB arrives first so new bits enter at the top.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= {data_i, sr_reg[8:1]};
    end
  end

  // Classify the symbol held in sr at a boundary.
  always_comb begin
    comma_ev    = 1'b0;
    abort_ev    = 1'b0;
    store_ev    = 1'b0;
    complete_ev = 1'b0;
    bad_ev      = 1'b0;
    if (boundary) begin
      if (is_comma) begin
        comma_ev = 1'b1;
        abort_ev = (slot_reg >= 2'd2);
      end else if (is_k) begin
        bad_ev = 1'b1;
      end else if (slot_reg == 2'd0) begin
        bad_ev = 1'b1;
      end else begin
        store_ev    = 1'b1;
        complete_ev = (slot_reg == 2'd3);
      end
    end
  end

  assign miss_hit = bad_ev && (miss_inc == MISS_LIMIT);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HUNT: begin
        if (is_comma) begin
          state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (miss_hit) begin
          state_next = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    lock_o = 1'b0;
    if (state_reg == ST_LOCKED) begin
      lock_o = 1'b1;
    end
  end

  // Bit, slot and miss counters track the frame position while locked.
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    slot_next    = slot_reg;
    miss_next    = miss_reg;
    if (state_reg == ST_HUNT) begin
      bit_cnt_next = 4'd0;
      miss_next    = 4'd0;
      slot_next    = is_comma ? 2'd1 : 2'd0;
    end else begin
      bit_cnt_next = (bit_cnt_reg == LAST_BIT) ? 4'd0 : bit_cnt_reg + 4'd1;
      if (miss_hit) begin
        bit_cnt_next = 4'd0;
        slot_next    = 2'd0;
        miss_next    = 4'd0;
      end else if (comma_ev) begin
        slot_next = 2'd1;
        miss_next = 4'd0;
      end else if (bad_ev) begin
        slot_next = 2'd0;
        miss_next = miss_inc;
      end else if (store_ev) begin
        slot_next = complete_ev ? 2'd0 : slot_reg + 2'd1;
        miss_next = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_reg <= '0;
      slot_reg    <= '0;
      miss_reg    <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      slot_reg    <= slot_next;
      miss_reg    <= miss_next;
    end
  end

  // Staging lanes for the first two data bytes; the third goes straight to data_o.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lane_reg <= '0;
      end else if (store_ev && (slot_reg == 2'(gi + 1))) begin
        lane_reg <= sr_reg[7:0];
      end
    end
    assign lanes[gi] = lane_reg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      valid_reg <= complete_ev;
      err_reg   <= abort_ev | bad_ev;
      if (complete_ev) begin
        data_reg      <= {sr_reg[7:0], lanes[1], lanes[0]};
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign err_o       = err_reg;
  assign slot_o      = slot_reg;
  assign frame_cnt_o = frame_cnt_reg;

endmodule

// File: tb/tb_deserializer_out.sv
// Self-checking bench for deserializer_out: frame scoreboard, vector table and
// hand-written sequences for alignment, abort, lock loss and async reset.
module tb_deserializer_out;

  logic        clk_i;
  logic        rst_ni;
  logic        data_i;
  logic [23:0] data_o;
  logic        valid_o;
  logic        lock_o;
  logic        err_o;
  logic [1:0]  slot_o;
  logic [15:0] frame_cnt_o;

  deserializer_out #(.MISS_MAX(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .lock_o     (lock_o),
    .err_o      (err_o),
    .slot_o     (slot_o),
    .frame_cnt_o(frame_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [8:0] COMMA = 9'h13C;

  typedef struct {
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs [4];
  int          tests = 0;
  int          fails = 0;
  int          err_cnt = 0;
  int          valid_cnt = 0;
  int          exp_frames = 0;
  logic [23:0] exp_q [$];
  logic [23:0] exp_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic send_sym(input logic [8:0] sym);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      data_i = sym[i];
    end
  endtask

  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [23:0] exp);
    exp_q.push_back(exp);
    send_sym(COMMA);
    send_sym({1'b0, d0});
    send_sym({1'b0, d1});
    send_sym({1'b0, d2});
  endtask

  // Scoreboard: every valid_o pulse must match the oldest queued frame.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_frames = 0;
    end else begin
      if (err_o) err_cnt++;
      if (valid_o) begin
        valid_cnt++;
        check("valid_err_exclusive", {31'b0, err_o}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got data 0x%0h, expected no frame", data_o);
        end else begin
          exp_d = exp_q.pop_front();
          exp_frames++;
          check("frame_data", {8'b0, data_o}, {8'b0, exp_d});
          check("frame_cnt", {16'b0, frame_cnt_o}, 32'(exp_frames));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int v0;
    vecs[0] = '{d0: 8'h01, d1: 8'h80, d2: 8'hFF, exp: 24'hFF8001};
    vecs[1] = '{d0: 8'hDE, d1: 8'hAD, d2: 8'hBE, exp: 24'hBEADDE};
    vecs[2] = '{d0: 8'h00, d1: 8'h00, d2: 8'h00, exp: 24'h000000};
    vecs[3] = '{d0: 8'h3C, d1: 8'hBC, d2: 8'h7E, exp: 24'h7EBC3C};

    // Reset with random line activity
    rst_ni = 1'b0;
    data_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      data_i = 1'($urandom);
    end
    check("rst_data", {8'b0, data_o}, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_lock", {31'b0, lock_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_slot", {30'b0, slot_o}, 32'd0);
    check("rst_frame_cnt", {16'b0, frame_cnt_o}, 32'd0);
    @(negedge clk_i);
    data_i = 1'b0;
    rst_ni = 1'b1;

    // Alignment: lock one cycle after the comma is complete in sr
    send_sym(COMMA);
    fork
      send_sym(COMMA);
      begin
        @(negedge clk_i);
        check("lock_comma_cycle", {31'b0, lock_o}, 32'd0);
        @(negedge clk_i);
        check("lock_next_cycle", {31'b0, lock_o}, 32'd1);
      end
    join
    send_sym(COMMA);
    check("idle_slot", {30'b0, slot_o}, 32'd1);

    // Clean frame with latency check
    send_frame(8'hA5, 8'h5A, 8'hC3, 24'hC35AA5);
    fork
      send_sym(COMMA);
      begin
        @(negedge clk_i);
        check("valid_boundary_cycle", {31'b0, valid_o}, 32'd0);
        @(negedge clk_i);
        check("valid_two_edges", {31'b0, valid_o}, 32'd1);
        check("data_two_edges", {8'b0, data_o}, 32'h00C35AA5);
      end
    join
    check("idle_no_err", 32'(err_cnt), 32'd0);

    // Vector table
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].exp);
    end
    send_sym(COMMA);
    check("table_no_err", 32'(err_cnt), 32'd0);
    check("table_frames", 32'(valid_cnt), 32'd5);

    // Bit offset: 5 idle bits before the comma stream
    @(negedge clk_i);
    rst_ni = 1'b0;
    data_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      data_i = 1'b0;
    end
    send_sym(COMMA);
    send_sym(COMMA);
    check("offset_lock", {31'b0, lock_o}, 32'd1);
    send_frame(8'h01, 8'h02, 8'h03, 24'h030201);
    send_sym(COMMA);
    check("offset_data", {8'b0, data_o}, 32'h00030201);

    // Abort: comma mid-frame discards the partial frame
    e0 = err_cnt;
    v0 = valid_cnt;
    exp_q.push_back(24'h665544);
    send_sym(COMMA);
    send_sym(9'h011);
    send_sym(9'h022);
    send_sym(COMMA);
    send_sym(9'h044);
    send_sym(9'h055);
    send_sym(9'h066);
    send_sym(COMMA);
    check("abort_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("abort_valid_pulses", 32'(valid_cnt - v0), 32'd1);

    // Lock loss after MISS_MAX data symbols at slot 0
    send_frame(8'h12, 8'h34, 8'h56, 24'h563412);
    e0 = err_cnt;
    send_sym(9'h000);
    send_sym(9'h000);
    send_sym(9'h000);
    check("miss_still_locked", {31'b0, lock_o}, 32'd1);
    send_sym(9'h000);
    fork
      send_sym(COMMA);
      begin
        @(negedge clk_i);
        check("loss_boundary_lock", {31'b0, lock_o}, 32'd1);
        @(negedge clk_i);
        check("loss_lock_low", {31'b0, lock_o}, 32'd0);
      end
    join
    check("loss_err_pulses", 32'(err_cnt - e0), 32'd4);
    send_sym(COMMA);
    check("relock", {31'b0, lock_o}, 32'd1);
    send_frame(8'h9A, 8'hBC, 8'hDE, 24'hDEBC9A);
    send_sym(COMMA);
    check("relock_err_pulses", 32'(err_cnt - e0), 32'd4);

    // Async reset between data symbols 2 and 3
    send_sym(COMMA);
    send_sym(9'h0AA);
    send_sym(9'h0BB);
    v0 = valid_cnt;
    #2 rst_ni = 1'b0;
    #1;
    check("async_data", {8'b0, data_o}, 32'd0);
    check("async_lock", {31'b0, lock_o}, 32'd0);
    check("async_frame_cnt", {16'b0, frame_cnt_o}, 32'd0);
    check("async_slot", {30'b0, slot_o}, 32'd0);
    send_sym(9'h0CC);
    @(negedge clk_i);
    data_i = 1'b0;
    rst_ni = 1'b1;
    send_sym(9'h000);
    check("async_no_stale_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h0F, 8'hF0, 8'h3C, 24'h3CF00F);
    send_sym(COMMA);
    check("async_next_frame", 32'(valid_cnt - v0), 32'd1);
    check("async_frame_cnt_after", {16'b0, frame_cnt_o}, 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
